sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for a single-ported async SRAM; each access takes WAIT_CYCLES+1 clocks
// (WAIT_CYCLES ACCESS + 1 DONE). A losing or busy port sees readyN low and must hold its request stable.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_en0,
    input  logic        w_en0,
    input  logic [16:0] addr0,
    input  logic [31:0] wdata0,
    output logic [31:0] rdata0,
    output logic        ready0,
    input  logic        r_en1,
    input  logic        w_en1,
    input  logic [16:0] addr1,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata1,
    output logic        ready1,
    inout  wire  [31:0] sram_dq,
    output logic        sram_we_n,
    output logic [16:0] sram_address,
    output logic        grant,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        wr_q, wr_d;
    logic        we_n_q, we_n_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        req0, req1, win;

    assign req0 = r_en0 | w_en0;
    assign req1 = r_en1 | w_en1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        wr_d     = wr_q;
        we_n_d   = we_n_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        win      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    // On a tie the port that did not own the bus last time wins.
                    win     = (req0 & req1) ? ~last_q : req1;
                    grant_d = win;
                    addr_d  = win ? addr1 : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    wr_d    = win ? w_en1 : w_en0;
                    we_n_d  = win ? ~w_en1 : ~w_en0;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    we_n_d  = 1'b1;
                    state_d = DONE;
                    if (!wr_q) begin
                        if (grant_q) rdata1_d = sram_dq;
                        else         rdata0_d = sram_dq;
                    end
                end
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            we_n_q   <= 1'b1;
            cnt_q    <= 4'd0;
            addr_q   <= 17'd0;
            wdata_q  <= 32'd0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            we_n_q   <= we_n_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // we_n is low only during write ACCESS cycles, so it doubles as the bus output enable.
    assign sram_dq      = we_n_q ? {32{1'bz}} : wdata_q;
    assign sram_we_n    = we_n_q;
    assign sram_address = addr_q;
    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign ready0       = ~req0 | ((state_q == DONE) & ~grant_q);
    assign ready1       = ~req1 | ((state_q == DONE) & grant_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level model scored every cycle, directed cases plus random traffic.
module tb_sram_arbiter;
    localparam int W = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_en0 = 1'b0, w_en0 = 1'b0, r_en1 = 1'b0, w_en1 = 1'b0;
    logic [16:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, sram_we_n, grant, busy;
    logic [16:0] sram_address;
    wire  [31:0] sram_dq;

    logic [31:0] mem     [0:131071];
    logic [31:0] ref_mem [0:131071];

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit chk_en = 1'b0;

    // Transaction-level model: one outstanding access and how many cycles it has run.
    bit          m_act, m_port, m_wr, m_last, m_grant;
    int          m_ph;
    logic [16:0] m_addr, m_sa;
    logic [31:0] m_data;
    logic [31:0] m_rd [2];
    bit          prev_rdy [2];
    bit          wr_acc;

    int lat, we_lo, l0, l1, fall;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .r_en0(r_en0), .w_en0(w_en0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0), .ready0(ready0),
        .r_en1(r_en1), .w_en1(w_en1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1), .ready1(ready1),
        .sram_dq(sram_dq), .sram_we_n(sram_we_n), .sram_address(sram_address),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    assign sram_dq = sram_we_n ? mem[sram_address] : {32{1'bz}};
    always @(posedge clk) if (!sram_we_n) mem[sram_address] <= sram_dq;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_req(bit n);
        return n ? (r_en1 | w_en1) : (r_en0 | w_en0);
    endfunction

    function automatic bit m_ready(bit n);
        return !m_req(n) || (m_act && m_ph == W + 1 && m_port == n);
    endfunction

    task automatic m_reset();
        m_act = 0; m_ph = 0; m_last = 1; m_grant = 0; m_sa = '0;
        m_rd[0] = '0; m_rd[1] = '0;
    endtask

    task automatic m_advance();
        bit p;
        if (!m_act) begin
            if (m_req(0) || m_req(1)) begin
                p = (m_req(0) && m_req(1)) ? !m_last : m_req(1);
                m_port = p; m_grant = p;
                m_wr   = p ? w_en1 : w_en0;
                m_addr = p ? addr1 : addr0;
                m_data = p ? wdata1 : wdata0;
                m_sa   = m_addr;
                m_act  = 1; m_ph = 1;
            end
        end else if (m_ph <= W) begin
            if (m_ph == 1 && m_wr) ref_mem[m_addr] = m_data;
            if (m_ph == W && !m_wr) m_rd[m_port] = ref_mem[m_addr];
            m_ph++;
        end else begin
            m_last = m_port;
            m_act  = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        prev_rdy[0] = m_ready(0);
        prev_rdy[1] = m_ready(1);
        if (!rst) m_reset();
        else      m_advance();
        cyc++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            wr_acc = m_act && m_ph <= W && m_wr;
            chk("busy",   32'(busy),      32'(m_act));
            chk("grant",  32'(grant),     32'(m_grant));
            chk("addr",   32'(sram_address), 32'(m_sa));
            chk("we_n",   32'(sram_we_n), 32'(!wr_acc));
            chk("ready0", 32'(ready0),    32'(m_ready(0)));
            chk("ready1", 32'(ready1),    32'(m_ready(1)));
            chk("rdata0", rdata0, m_rd[0]);
            chk("rdata1", rdata1, m_rd[1]);
            if (wr_acc) chk("dq", sram_dq, m_data);
        end
    end

    task automatic set_port(input bit p, input bit r, input bit w,
                            input logic [16:0] a, input logic [31:0] d);
        if (p) begin r_en1 = r; w_en1 = w; addr1 = a; wdata1 = d; end
        else   begin r_en0 = r; w_en0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic single(input bit p, input bit r, input bit w, input logic [16:0] a,
                          input logic [31:0] d, output int l, output int wl);
        int  t0;
        bit  got;
        tick();
        set_port(p, r, w, a, d);
        t0 = cyc; l = -1; wl = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (!sram_we_n && sram_dq === d) wl++;
            if (p ? ready1 : ready0) begin got = 1; l = cyc - t0; end
        end
        if (!got) chk("single_timeout", 32'(0), 32'(1));
        set_port(p, 0, 0, a, d);
    endtask

    task automatic conflict(input logic [16:0] a0v, input logic [16:0] a1v,
                            output int c0, output int c1);
        int t0;
        tick();
        set_port(0, 1, 0, a0v, '0);
        set_port(1, 1, 0, a1v, '0);
        t0 = cyc; c0 = -1; c1 = -1;
        for (int i = 0; i < 40 && (c0 < 0 || c1 < 0); i++) begin
            tick();
            if (c0 < 0 && ready0) begin c0 = cyc - t0; r_en0 = 0; end
            if (c1 < 0 && ready1) begin c1 = cyc - t0; r_en1 = 0; end
        end
        if (c0 < 0 || c1 < 0) chk("conflict_timeout", 32'(0), 32'(1));
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        #1 rst = 1'b0;
        m_reset();
        chk_en = 1'b1;
        tick();
        chk("rst_we_n",   32'(sram_we_n), 32'(1));
        chk("rst_addr",   32'(sram_address), 32'(0));
        chk("rst_grant",  32'(grant), 32'(0));
        chk("rst_busy",   32'(busy), 32'(0));
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        rst = 1'b1;

        // First conflict after reset: port 0 first, port 1 completes 13 cycles later.
        conflict(17'h100, 17'h200, l0, l1);
        chk("c1_lat0", 32'(l0), 32'(6));
        chk("c1_lat1", 32'(l1), 32'(13));
        chk("c1_rd0", rdata0, init_word(17'h100));
        chk("c1_rd1", rdata1, init_word(17'h200));

        single(0, 1, 0, 17'h300, '0, lat, we_lo);
        chk("p0rd_lat", 32'(lat), 32'(6));
        chk("p0rd_val", rdata0, init_word(17'h300));

        // Port 0 owned the bus last, so port 1 wins the next tie.
        conflict(17'h110, 17'h210, l0, l1);
        chk("c2_lat1", 32'(l1), 32'(6));
        chk("c2_lat0", 32'(l0), 32'(13));

        single(0, 0, 1, 17'h00010, 32'hDEADBEEF, lat, we_lo);
        chk("wr_lat",  32'(lat), 32'(6));
        chk("wr_we_lo", 32'(we_lo), 32'(5));

        single(0, 1, 0, 17'h00010, 32'h0, lat, we_lo);
        chk("rd_lat",  32'(lat), 32'(6));
        chk("rd_we_lo", 32'(we_lo), 32'(0));
        chk("rd_val",  rdata0, 32'hDEADBEEF);
        repeat (3) tick();
        chk("rd_hold", rdata0, 32'hDEADBEEF);

        single(1, 1, 1, 17'h1FFFF, 32'h00000001, lat, we_lo);
        chk("rw_lat",   32'(lat), 32'(6));
        chk("rw_we_lo", 32'(we_lo), 32'(5));
        chk("rw_rdata1", rdata1, init_word(17'h210));
        single(1, 1, 0, 17'h1FFFF, 32'h0, lat, we_lo);
        chk("top_rd", rdata1, 32'h00000001);

        // Reset lands in the third ACCESS cycle of a write.
        tick();
        set_port(0, 0, 1, 17'h30, 32'hCAFEF00D);
        repeat (3) tick();
        rst = 1'b0;
        m_reset();
        #1;
        chk("arst_we_n", 32'(sram_we_n), 32'(1));
        chk("arst_busy", 32'(busy), 32'(0));
        tick();
        chk("arst_rdy0", 32'(ready0), 32'(0));
        set_port(0, 0, 0, '0, '0);
        rst = 1'b1;
        single(0, 1, 0, 17'h30, 32'h0, lat, we_lo);
        chk("arst_rd_lat", 32'(lat), 32'(6));
        chk("arst_rd_val", rdata0, 32'hCAFEF00D);

        // Request withdrawn mid-access.
        tick();
        set_port(0, 1, 0, 17'h40, '0);
        lat = cyc;
        repeat (2) tick();
        set_port(0, 0, 0, '0, '0);
        fall = -1;
        for (int i = 0; i < 20 && fall < 0; i++) begin
            tick();
            chk("wd_rdy0", 32'(ready0), 32'(1));
            if (!busy) fall = cyc - lat;
        end
        chk("wd_busy_fall", 32'(fall), 32'(7));
        chk("wd_rdata0", rdata0, init_word(17'h40));

        // Random traffic: requesters hold until their ready was seen, occasionally withdraw.
        repeat (3000) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                if (m_req(n[0]) && !prev_rdy[n]) begin
                    if ($urandom_range(0, 49) == 0) set_port(n[0], 0, 0, '0, '0);
                end else if ($urandom_range(0, 9) < 4) begin
                    int op;
                    logic [16:0] a;
                    op = $urandom_range(0, 2);
                    a  = ($urandom_range(0, 7) == 0) ? 17'h1FFFF : 17'($urandom_range(0, 15));
                    set_port(n[0], op != 1, op != 0, a, $urandom);
                end else begin
                    set_port(n[0], 0, 0, '0, '0);
                end
            end
        end
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
        repeat (20) tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
